// File: rtl/stream_min_tracker.sv
// rtl/stream_min_tracker.sv - frame-based running minimum (optional running maximum) of an unsigned word stream
// Optional feature macro: STREAM_MIN_TRACKER_MAX_EN adds out_max / out_max_idx.

module stream_min_tracker #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
`ifdef STREAM_MIN_TRACKER_MAX_EN
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_max_idx,
`endif
    output logic [IDX_W-1:0] out_count
);

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACC   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] CNT_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] CNT_MAX = {IDX_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_min_q, out_min_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] out_count_q, out_count_d;

    logic             accept;
    logic             handshake;
    logic             keep_min;
    logic [IDX_W-1:0] cnt_inc;

`ifdef STREAM_MIN_TRACKER_MAX_EN
    logic [WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [WIDTH-1:0] out_max_q, out_max_d;
    logic [IDX_W-1:0] out_max_idx_q, out_max_idx_d;
    logic             keep_max;
`endif

    // Input side is ready whenever no result is being held; depends on state only.
    assign in_ready  = (state_q != ST_DONE);
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid_q & out_ready;

    // Comparator relations and the saturating beat counter increment.
    always_comb begin
        keep_min = (min_q <= in_data);
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
`ifdef STREAM_MIN_TRACKER_MAX_EN
        keep_max = !(max_q <= in_data) || (max_q == in_data);
`endif
    end

    // Next-state logic: load on beat 0, track running extremes, latch result on last beat.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_min_d   = out_min_q;
        out_idx_d   = out_idx_q;
        out_count_d = out_count_q;
`ifdef STREAM_MIN_TRACKER_MAX_EN
        max_d         = max_q;
        max_idx_d     = max_idx_q;
        out_max_d     = out_max_q;
        out_max_idx_d = out_max_idx_q;
`endif
        case (state_q)
            ST_FIRST: begin
                if (accept) begin
                    min_d   = in_data;
                    idx_d   = '0;
                    cnt_d   = CNT_ONE;
`ifdef STREAM_MIN_TRACKER_MAX_EN
                    max_d     = in_data;
                    max_idx_d = '0;
`endif
                    state_d = in_last ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    // A beat's index equals the pre-increment count, which pins at CNT_MAX once saturated.
                    if (!keep_min) begin
                        min_d = in_data;
                        idx_d = cnt_q;
                    end
`ifdef STREAM_MIN_TRACKER_MAX_EN
                    if (!keep_max) begin
                        max_d     = in_data;
                        max_idx_d = cnt_q;
                    end
`endif
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FIRST;
                end
            end
            default: begin
                state_d = ST_FIRST;
            end
        endcase

        // The final beat is folded in before the result is captured.
        if (accept && in_last) begin
            out_valid_d = 1'b1;
            out_min_d   = min_d;
            out_idx_d   = idx_d;
            out_count_d = cnt_d;
`ifdef STREAM_MIN_TRACKER_MAX_EN
            out_max_d     = max_d;
            out_max_idx_d = max_idx_d;
`endif
        end
    end

    // State registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FIRST;
            min_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_idx_q   <= '0;
            out_count_q <= '0;
`ifdef STREAM_MIN_TRACKER_MAX_EN
            max_q         <= '0;
            max_idx_q     <= '0;
            out_max_q     <= '0;
            out_max_idx_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_min_q   <= out_min_d;
            out_idx_q   <= out_idx_d;
            out_count_q <= out_count_d;
`ifdef STREAM_MIN_TRACKER_MAX_EN
            max_q         <= max_d;
            max_idx_q     <= max_idx_d;
            out_max_q     <= out_max_d;
            out_max_idx_q <= out_max_idx_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_min   = out_min_q;
    assign out_idx   = out_idx_q;
    assign out_count = out_count_q;
`ifdef STREAM_MIN_TRACKER_MAX_EN
    assign out_max     = out_max_q;
    assign out_max_idx = out_max_idx_q;
`endif

endmodule
